// File: rtl/multiplier_seq_pkg.sv
// Shared types and width helpers for the sequential radix-2 multiplier.
package multiplier_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/multiplier_seq_step.sv
// One radix-2 shift-add step: conditional accumulate, then shift both operands.
module multiplier_seq_step
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [prod_width(WIDTH)-1:0] acc,
  input  logic [prod_width(WIDTH)-1:0] mcand,
  input  logic [WIDTH-1:0]             mplier,
  output logic [prod_width(WIDTH)-1:0] acc_next,
  output logic [prod_width(WIDTH)-1:0] mcand_next,
  output logic [WIDTH-1:0]             mplier_next
);

  always_comb begin
    acc_next    = mplier[0] ? acc + mcand : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/multiplier_seq.sv
// Iterative WIDTH-cycle multiplier with valid/ready handshakes on both sides.
// Define MULTIPLIER_SEQ_SIGNED_EN to honour signed_mode (magnitude + final negate).
module multiplier_seq
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic                         signed_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [prod_width(WIDTH)-1:0] product
);

  localparam int PW = prod_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t            state;
  logic [PW-1:0]     acc, mcand, acc_nx, mcand_nx, result;
  logic [WIDTH-1:0]  mplier, mplier_nx, a_mag, b_mag;
  logic [CNT_W-1:0]  cnt;

`ifdef MULTIPLIER_SEQ_SIGNED_EN
  logic neg, neg_in;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct read as unsigned.
  always_comb begin
    a_mag  = (signed_mode && A[WIDTH-1]) ? -A : A;
    b_mag  = (signed_mode && B[WIDTH-1]) ? -B : B;
    neg_in = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  assign result = neg ? -acc_nx : acc_nx;
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;
  assign a_mag  = A;
  assign b_mag  = B;
  assign result = acc_nx;
`endif

  multiplier_seq_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_next   (acc_nx),
    .mcand_next (mcand_nx),
    .mplier_next(mplier_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= '0;
            mcand    <= PW'(a_mag);
            mplier   <= b_mag;
            cnt      <= '0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
            neg      <= neg_in;
`endif
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand_nx;
          mplier <= mplier_nx;
          cnt    <= cnt + CNT_W'(1);
          // Final step result goes straight to the output register.
          if (cnt == LAST_STEP) begin
            product   <= result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
